// File: rtl/ixc_xfer_pkg.sv
// Shared types and helpers for the wide transfer arbiter.
// Holds the FSM encoding and the round-robin pick function.
package ixc_xfer_pkg;

   localparam int DW_DEFAULT = 288;
   localparam int N_MAX      = 8;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   // First set bit searching ptr+1, ptr+2, ... modulo n.
   function automatic logic [2:0] rr_pick(
      input logic [N_MAX-1:0] valid,
      input logic [2:0]       ptr,
      input int               n
   );
      logic [2:0] idx;
      logic       found;
      int         j;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= N_MAX; k++) begin
         j = (int'(ptr) + k) % n;
         if (k <= n && !found && valid[j]) begin
            idx   = 3'(j);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/ixc_wide_xfer_arb_rr_pick.sv
// Combinational round-robin priority encoder.
// Thin N_REQ-parametrised wrapper around the package pick function.
module ixc_rr_pick
   import ixc_xfer_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IDW-1:0]   ptr,
   output logic [IDW-1:0]   idx,
   output logic             any
);

   assign idx = IDW'(rr_pick(N_MAX'(valid), 3'(ptr), N_REQ));
   assign any = |valid;

endmodule

// File: rtl/ixc_wide_xfer_arb.sv
// Round-robin burst arbiter sharing one wide datapath.
// Grant is held for a whole burst; output is a one-entry register stage.
module ixc_wide_xfer_arb
   import ixc_xfer_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int DW    = DW_DEFAULT,
   parameter int IDW   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*DW-1:0] req_data,
   input  logic [N_REQ-1:0]    req_last,
   output logic [N_REQ-1:0]    req_ready,
   output logic                out_valid,
   output logic [DW-1:0]       out_data,
   output logic                out_last,
   output logic [IDW-1:0]      out_id,
   input  logic                out_ready,
   output logic                busy
);

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] pick_id;
   logic           pick_any;
   logic           stage_free;
   logic           accept;
   logic           gnt_valid;
   logic           gnt_last;
   logic [DW-1:0]  gnt_data;
   logic [DW-1:0]  data_arr [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*DW +: DW];
   end

   ixc_rr_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .idx   (pick_id),
      .any   (pick_any)
   );

   assign gnt_valid  = req_valid[gnt_id];
   assign gnt_last   = req_last[gnt_id];
   assign gnt_data   = data_arr[gnt_id];
   assign stage_free = !out_valid || out_ready;
   assign accept     = (state == LOCK) && gnt_valid && stage_free;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (pick_any) state_nxt = LOCK;
         LOCK: if (accept && gnt_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      busy      = (state == LOCK);
      if (state == LOCK) req_ready[gnt_id] = stage_free;
   end

   // Pointer moves only when a burst completes, so a stalled
   // requester keeps its grant for as long as it needs.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= IDW'(N_REQ - 1);
         gnt_id <= '0;
      end else begin
         if (state == IDLE && pick_any) gnt_id <= pick_id;
         if (accept && gnt_last)        rr_ptr <= gnt_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_id    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= gnt_data;
         out_last  <= gnt_last;
         out_id    <= gnt_id;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ixc_wide_xfer_arb.sv
// Scoreboard bench for ixc_wide_xfer_arb: directed bursts per requester,
// expected beats queued at issue time and checked on each output handshake.
module tb_ixc_wide_xfer_arb;

   localparam int N   = 4;
   localparam int DW  = 288;
   localparam int IDW = 2;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   typedef struct {
      logic [DW-1:0]  d;
      logic           l;
      logic [IDW-1:0] id;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_last;
   logic [N-1:0]      req_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              out_last;
   logic [IDW-1:0]    out_id;
   logic              out_ready;
   logic              busy;

   beat_t        dq [N][$];
   exp_t         sb [$];
   logic [N-1:0] hold;
   logic [N-1:0] pend;
   int           checks;
   int           errors;

   ixc_wide_xfer_arb #(
      .N_REQ (N),
      .DW    (DW),
      .IDW   (IDW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_id    (out_id),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk(input logic [15:0] t);
      return {18{t}};
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add_beat(input int r, input logic [15:0] t, input logic l);
      beat_t b;
      b.d = mk(t);
      b.l = l;
      dq[r].push_back(b);
   endtask

   task automatic add_exp(input int r, input logic [15:0] t, input logic l);
      exp_t e;
      e.d  = mk(t);
      e.l  = l;
      e.id = IDW'(r);
      sb.push_back(e);
   endtask

   task automatic burst(input int r, input int n, input logic [15:0] base,
                        input bit expect_out);
      for (int b = 0; b < n; b++) begin
         add_beat(r, base + 16'(b), b == n - 1);
         if (expect_out) add_exp(r, base + 16'(b), b == n - 1);
      end
   endtask

   function automatic bit pending_work();
      bit w;
      w = (sb.size() != 0);
      for (int i = 0; i < N; i++) if (dq[i].size() != 0) w = 1'b1;
      return w;
   endfunction

   task automatic drain();
      int n;
      n = 0;
      while (pending_work() && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", DW'(sb.size()), '0);
      repeat (3) @(negedge clk);
   endtask

   // Requester driver: present queue head, pop after a seen handshake.
   always @(negedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (pend[i] && dq[i].size() > 0) dq[i].delete(0);
         if (!hold[i] && dq[i].size() > 0) begin
            req_valid[i]            = 1'b1;
            req_data[i*DW +: DW]    = dq[i][0].d;
            req_last[i]             = dq[i][0].l;
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
         end
      end
      #1;
      for (int i = 0; i < N; i++)
         pend[i] = req_valid[i] && req_ready[i] && !rst;
   end

   // Output monitor: every downstream handshake pops one expected beat.
   always @(negedge clk) begin
      #3;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got id %0d data %h expected none",
                     out_id, out_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("beat_data", out_data, e.d);
            chk("beat_last", DW'(out_last), DW'(e.l));
            chk("beat_id", DW'(out_id), DW'(e.id));
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      out_ready = 1'b1;
      hold      = '0;
      pend      = '0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;

      repeat (3) @(negedge clk);
      #4;
      chk("rst_out_valid", DW'(out_valid), '0);
      chk("rst_out_last", DW'(out_last), '0);
      chk("rst_out_id", DW'(out_id), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_busy", DW'(busy), '0);
      chk("rst_req_ready", DW'(req_ready), '0);

      // 3-beat burst on requester 0
      @(negedge clk);
      rst = 1'b0;
      burst(0, 3, 16'h00A0, 1'b1);
      #4;
      chk("t1_idle_busy", DW'(busy), '0);
      chk("t1_idle_ready", DW'(req_ready), '0);
      @(negedge clk); #4;
      chk("t1_grant_busy", DW'(busy), 1);
      chk("t1_grant_ready", DW'(req_ready), DW'(4'b0001));
      @(negedge clk); #4;
      chk("t1_b0_valid", DW'(out_valid), 1);
      @(negedge clk); #4;
      chk("t1_b1_valid", DW'(out_valid), 1);
      @(negedge clk); #4;
      chk("t1_b2_valid", DW'(out_valid), 1);
      chk("t1_b2_last", DW'(out_last), 1);
      chk("t1_end_busy", DW'(busy), '0);
      chk("t1_end_ready", DW'(req_ready), '0);
      drain();

      // rr_ptr=0 with requesters 0 and 1 valid: 1 wins first
      @(negedge clk);
      add_beat(1, 16'h0611, 1'b1);
      add_beat(0, 16'h0600, 1'b1);
      add_exp(1, 16'h0611, 1'b1);
      add_exp(0, 16'h0600, 1'b1);
      @(negedge clk); #4;
      chk("t6_grant_ready", DW'(req_ready), DW'(4'b0010));
      drain();

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #4;
      chk("rst2_out_valid", DW'(out_valid), '0);
      chk("rst2_busy", DW'(busy), '0);
      @(negedge clk);
      rst = 1'b0;

      // all four valid, single-beat bursts, two rounds
      for (int r = 0; r < N; r++) begin
         add_beat(r, 16'h0200 + 16'(r), 1'b1);
         add_beat(r, 16'h0204 + 16'(r), 1'b1);
      end
      for (int r = 0; r < N; r++) add_exp(r, 16'h0200 + 16'(r), 1'b1);
      for (int r = 0; r < N; r++) add_exp(r, 16'h0204 + 16'(r), 1'b1);
      drain();

      // requester 2 stalled by downstream for 5 cycles
      @(negedge clk);
      burst(2, 4, 16'h0C00, 1'b1);
      @(negedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         #4;
         chk("t3_valid", DW'(out_valid), 1);
         chk("t3_data", out_data, mk(16'h0C00));
         chk("t3_id", DW'(out_id), 2);
         chk("t3_ready", DW'(req_ready), '0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      drain();

      // requester 1 pauses mid-burst while requester 3 waits
      @(negedge clk);
      burst(1, 4, 16'h0D00, 1'b1);
      @(negedge clk);
      @(negedge clk);
      hold[1] = 1'b1;
      burst(3, 1, 16'h0E00, 1'b1);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #4;
         chk("t4_busy", DW'(busy), 1);
         chk("t4_ready", DW'(req_ready), DW'(4'b0010));
      end
      @(negedge clk);
      hold[1] = 1'b0;
      drain();

      // move rr_ptr to 1, then reset during beat 2 of a 4-beat burst
      @(negedge clk);
      burst(1, 1, 16'h0500, 1'b1);
      drain();
      @(negedge clk);
      burst(0, 4, 16'h0F00, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      dq[0].delete();
      burst(1, 1, 16'h0510, 1'b1);
      burst(2, 2, 16'h0520, 1'b1);
      #4;
      chk("t5_out_valid", DW'(out_valid), '0);
      chk("t5_busy", DW'(busy), '0);
      chk("t5_ready", DW'(req_ready), '0);
      @(negedge clk); #4;
      chk("t5_regrant", DW'(req_ready), DW'(4'b0010));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
